// File: rtl/ceres_param.sv
// Shared types and constants for the D-cache port arbiter and its requesters.
package ceres_param;

   localparam int DCACHE_ARB_NUM_REQ = 2;
   localparam int ARB_IDX_LSU        = 0;
   localparam int ARB_IDX_PTW        = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic        valid;
      logic        ready;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dcache_req_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } dcache_res_t;

endpackage

// File: rtl/arb_prio_sel.sv
// Fixed-priority selector with starvation override: the lowest starved index wins,
// otherwise the lowest valid index. Purely combinational.
module arb_prio_sel #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid_i,
   input  logic [N-1:0]  starved_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   logic [N-1:0] cand;

   always_comb begin
      cand  = (|(starved_i & valid_i)) ? (starved_i & valid_i) : valid_i;
      gnt_o = '0;
      idx_o = '0;
      // Walk from the top down so the lowest candidate is the last one written.
      for (int k = N - 1; k >= 0; k--) begin
         if (cand[k]) begin
            gnt_o    = '0;
            gnt_o[k] = 1'b1;
            idx_o    = IW'(k);
         end
      end
   end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single D-cache port between NUM_REQ requesters, one transaction in
// flight; fixed priority with age-based promotion, response routed to the owner.
module dcache_port_arbiter
   import ceres_param::*;
#(
   parameter  int NUM_REQ      = DCACHE_ARB_NUM_REQ,
   parameter  int STARVE_LIMIT = 8,
   localparam int AGE_W        = $clog2(STARVE_LIMIT + 1),
   localparam int OW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  dcache_req_t        req_i [NUM_REQ],
   output logic [NUM_REQ-1:0] req_ready_o,
   output dcache_res_t        res_o [NUM_REQ],
   output dcache_req_t        dcache_req_o,
   input  dcache_res_t        dcache_res_i,
   output logic               busy_o,
   output logic [OW-1:0]      owner_o
);

   arb_state_e         state_q, state_d;
   logic [OW-1:0]      owner_q, owner_d;
   logic [AGE_W-1:0]   age_q [NUM_REQ];
   logic [AGE_W-1:0]   age_d [NUM_REQ];
   logic [NUM_REQ-1:0] valid_vec, starved_vec, gnt;
   logic [OW-1:0]      gnt_idx;

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         valid_vec[k]   = req_i[k].valid;
         starved_vec[k] = (age_q[k] == AGE_W'(STARVE_LIMIT));
      end
   end

   arb_prio_sel #(.N(NUM_REQ)) u_sel (
      .valid_i   (valid_vec),
      .starved_i (starved_vec),
      .gnt_o     (gnt),
      .idx_o     (gnt_idx)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      req_ready_o  = '0;
      dcache_req_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         res_o[k].valid = 1'b0;
         res_o[k].data  = dcache_res_i.data;
      end
      unique case (state_q)
         IDLE: begin
            // A response arriving here has no owner and is dropped.
            if (!flush_i && (|valid_vec)) begin
               req_ready_o        = gnt;
               dcache_req_o       = req_i[gnt_idx];
               dcache_req_o.valid = 1'b1;
               dcache_req_o.ready = 1'b1;
               owner_d            = gnt_idx;
               state_d            = BUSY;
            end
         end
         BUSY: begin
            if (dcache_res_i.valid) begin
               res_o[owner_q].valid = 1'b1;
               state_d              = IDLE;
            end else if (flush_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (dcache_res_i.valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         if (flush_i || !req_i[k].valid || req_ready_o[k]) age_d[k] = '0;
         else if (!starved_vec[k])                         age_d[k] = age_q[k] + AGE_W'(1);
         else                                              age_d[k] = age_q[k];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         owner_q <= '0;
         for (int k = 0; k < NUM_REQ; k++) age_q[k] <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         for (int k = 0; k < NUM_REQ; k++) age_q[k] <= age_d[k];
      end
   end

   assign busy_o  = (state_q != IDLE);
   assign owner_o = owner_q;

endmodule
